// File: rtl/md_iter_unit.sv
// md_iter_unit: iterative 32-cycle shift-add multiply / restoring divide feeding HI/LO
module md_iter_unit #(
  parameter int WIDTH = 32,
  parameter int CNT_W = 5
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [1:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo,
  output logic             div_zero
);
  typedef enum logic [1:0] {IDLE, CALC, FIX, DONE} state_t;
  state_t                 state;
  logic [CNT_W-1:0]       count;
  logic [2*WIDTH:0]       acc;
  logic [WIDTH-1:0]       opnd, a_raw;
  logic                   is_div, p_neg, r_neg, b_zero;
  logic                   sgn;
  logic [WIDTH-1:0]       a_mag, b_mag;
  logic [WIDTH:0]         mul_sum;
  logic [2*WIDTH:0]       mul_pre, mul_next, div_sh, div_next;
  logic [WIDTH+1:0]       div_diff;
  logic [2*WIDTH-1:0]     prod;
  logic [WIDTH-1:0]       quot, rem;
  // operand magnitudes, one shift-add / restoring step, and sign-corrected results
  always_comb begin
    sgn      = ~op[0];
    a_mag    = (sgn & a[WIDTH-1]) ? -a : a;
    b_mag    = (sgn & b[WIDTH-1]) ? -b : b;
    mul_sum  = {1'b0, acc[2*WIDTH-1:WIDTH]} + {1'b0, opnd};
    mul_pre  = acc[0] ? {mul_sum, acc[WIDTH-1:0]} : acc;
    mul_next = mul_pre >> 1;
    div_sh   = acc << 1;
    div_diff = {1'b0, div_sh[2*WIDTH:WIDTH]} - {2'b00, opnd};
    div_next = div_diff[WIDTH+1] ? div_sh : {div_diff[WIDTH:0], div_sh[WIDTH-1:1], 1'b1};
    prod     = p_neg ? -acc[2*WIDTH-1:0] : acc[2*WIDTH-1:0];
    quot     = b_zero ? '1 : (p_neg ? -acc[WIDTH-1:0] : acc[WIDTH-1:0]);
    rem      = b_zero ? a_raw : (r_neg ? -acc[2*WIDTH-1:WIDTH] : acc[2*WIDTH-1:WIDTH]);
  end
  // control FSM, iteration datapath and registered HI/LO outputs
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state    <= IDLE;
      count    <= '0;
      acc      <= '0;
      opnd     <= '0;
      a_raw    <= '0;
      is_div   <= 1'b0;
      p_neg    <= 1'b0;
      r_neg    <= 1'b0;
      b_zero   <= 1'b0;
      busy     <= 1'b0;
      done     <= 1'b0;
      div_zero <= 1'b0;
      hi       <= '0;
      lo       <= '0;
    end else begin
      done     <= 1'b0;
      div_zero <= 1'b0;
      case (state)
        IDLE: if (start) begin
          acc    <= {{(WIDTH+1){1'b0}}, op[1] ? a_mag : b_mag};
          opnd   <= op[1] ? b_mag : a_mag;
          a_raw  <= a;
          is_div <= op[1];
          p_neg  <= sgn & (a[WIDTH-1] ^ b[WIDTH-1]);
          r_neg  <= sgn & a[WIDTH-1];
          b_zero <= op[1] & (b == '0);
          count  <= '0;
          busy   <= 1'b1;
          state  <= CALC;
        end
        CALC: begin
          acc   <= is_div ? div_next : mul_next;
          count <= count + CNT_W'(1);
          if (count == CNT_W'(WIDTH-1)) state <= FIX;
        end
        FIX: begin
          hi       <= is_div ? rem : prod[2*WIDTH-1:WIDTH];
          lo       <= is_div ? quot : prod[WIDTH-1:0];
          done     <= 1'b1;
          div_zero <= b_zero;
          busy     <= 1'b0;
          state    <= DONE;
        end
        DONE: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_md_iter_unit.sv
// tb_md_iter_unit: scoreboard bench for the iterative multiply/divide unit
module tb_md_iter_unit;
  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic [1:0]  op = 2'b00;
  logic [31:0] a = '0, b = '0;
  logic        busy, done, div_zero;
  logic [31:0] hi, lo;
  typedef struct {
    logic [31:0] hi;
    logic [31:0] lo;
    logic        dz;
    int          cyc;
  } exp_t;
  exp_t sb[$];
  int   cyc = 0;
  int   n_cmp = 0;
  int   n_err = 0;

  md_iter_unit dut (
    .clk(clk), .rst_n(rst_n), .start(start), .op(op), .a(a), .b(b),
    .busy(busy), .done(done), .hi(hi), .lo(lo), .div_zero(div_zero)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, obs, exp, cyc);
    end
  endtask

  task automatic issue(input logic [1:0] o, input logic [31:0] x, input logic [31:0] y,
                       input bit push, input logic [31:0] eh, input logic [31:0] el, input logic ed);
    exp_t e;
    @(negedge clk);
    op = o; a = x; b = y; start = 1'b1;
    if (push) begin
      e.hi = eh; e.lo = el; e.dz = ed; e.cyc = cyc + 34;
      sb.push_back(e);
    end
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic drain();
    for (int i = 0; i < 100 && sb.size() != 0; i++) @(negedge clk);
    chk("drain_timeout", 64'(sb.size()), 0);
    @(negedge clk);
  endtask

  always @(negedge clk) begin
    if (rst_n) begin
      if (div_zero && !done) chk("dz_without_done", div_zero, 0);
      if (done) begin
        if (sb.size() == 0) chk("spurious_done", done, 0);
        else begin
          exp_t e;
          e = sb.pop_front();
          chk("hi", hi, e.hi);
          chk("lo", lo, e.lo);
          chk("div_zero", div_zero, e.dz);
          chk("latency", 64'(cyc), 64'(e.cyc));
          chk("busy_at_done", busy, 0);
        end
      end
    end
  end

  initial begin
    repeat (3) @(negedge clk);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_hilo", {hi, lo}, 0);
    rst_n = 1'b1;
    issue(2'b01, 32'd7, 32'd6, 1'b0, '0, '0, 1'b0);
    repeat (9) @(negedge clk);
    chk("busy_mid_op", busy, 1);
    rst_n = 1'b0;
    @(negedge clk);
    chk("midrst_busy", busy, 0);
    chk("midrst_hilo", {hi, lo}, 0);
    rst_n = 1'b1;
    repeat (40) @(negedge clk);
    chk("after_abandon_busy", busy, 0);
    chk("after_abandon_hilo", {hi, lo}, 0);
    issue(2'b01, 32'd7, 32'd6, 1'b1, 32'd0, 32'd42, 1'b0);
    drain();
    issue(2'b00, 32'hFFFF_FFFD, 32'd5, 1'b1, 32'hFFFF_FFFF, 32'hFFFF_FFF1, 1'b0);
    drain();
    issue(2'b01, 32'hFFFF_FFFD, 32'd5, 1'b1, 32'h4, 32'hFFFF_FFF1, 1'b0);
    drain();
    issue(2'b10, -32'sd7, 32'd2, 1'b1, 32'hFFFF_FFFF, 32'hFFFF_FFFD, 1'b0);
    drain();
    issue(2'b11, 32'd7, 32'd2, 1'b1, 32'd1, 32'd3, 1'b0);
    drain();
    issue(2'b11, 32'h1234, 32'd0, 1'b1, 32'h1234, 32'hFFFF_FFFF, 1'b1);
    drain();
    issue(2'b10, 32'h8000_0000, 32'hFFFF_FFFF, 1'b0, '0, '0, 1'b0);
    begin
      exp_t e;
      e.hi = 32'd0; e.lo = 32'h8000_0000; e.dz = 1'b0; e.cyc = cyc + 33;
      sb.push_back(e);
    end
    for (int i = 0; i < 60; i++) begin
      start = 1'b1; op = 2'($urandom); a = $urandom; b = $urandom;
      @(negedge clk);
      if (done) break;
    end
    chk("junk_loop_done", done, 1);
    start = 1'b1; op = 2'b00; a = 32'h55; b = 32'h3;
    issue(2'b01, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b1, 32'hFFFF_FFFE, 32'h0000_0001, 1'b0);
    drain();
    issue(2'b11, 32'd100, 32'd7, 1'b1, 32'd2, 32'd14, 1'b0);
    for (int i = 0; i < 5; i++) begin
      chk("hold_hi", hi, 32'hFFFF_FFFE);
      chk("hold_lo", lo, 32'h0000_0001);
      repeat (3) @(negedge clk);
    end
    drain();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
